skl_32_pipe_8: RTL

- Pipelined 32-bit adder built from four 8-bit Sklansky slices, with one slice per pipeline stage.
- The carry and the not-yet-consumed operand slices are registered between stages, giving a throughput of one add per cycle.
- Sits in the same adder library as the combinational ripple-of-Sklansky adders. It is the registered, elastic variant consumed by the PPA flow for timing-closed datapaths.
- Valid/ready handshake on input and output, with full backpressure.

---
 rtl/adder_pkg.sv | 17 +
 rtl/skl8.sv | 47 ++++
 rtl/skl_32_pipe_8.sv | 96 +++++++++
 3 files changed

// File: rtl/adder_pkg.sv
// Shared types and sizing for the adder library.
// stage_t is one pipeline register: the partial result plus the operand slices still to be added.
package adder_pkg;

  localparam int unsigned SLICE_W = 8;
  localparam int unsigned WIDTH   = 32;
  localparam int unsigned STAGES  = WIDTH / SLICE_W;

  typedef struct packed {
    logic             valid;
    logic             carry;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] x1;
    logic [WIDTH-1:0] x2;
  } stage_t;

endpackage

// File: rtl/skl8.sv
// 8-bit Sklansky parallel-prefix adder slice with carry-in and carry-out.
// The carry-in is folded into bit 0's generate so the prefix tree yields every carry directly.
module skl8
  import adder_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] s,
  output logic               cout
);

  localparam int unsigned LEVELS = $clog2(SLICE_W);

  logic [SLICE_W-1:0] p;
  logic [SLICE_W-1:0] g;
  logic [SLICE_W-1:0] gp;
  logic [SLICE_W-1:0] pp;
  logic [SLICE_W-1:0] gn;
  logic [SLICE_W-1:0] pn;

  // Each level joins the upper half of every 2^(l+1) block with the top bit of its lower half.
  always_comb begin
    p  = a ^ b;
    g  = a & b;
    gn = '0;
    pn = '0;
    gp = g;
    gp[0] = g[0] | (p[0] & cin);
    pp = p;
    for (int l = 0; l < int'(LEVELS); l++) begin
      gn = gp;
      pn = pp;
      for (int i = 0; i < int'(SLICE_W); i++) begin
        if (((i >> l) & 1) == 1) begin
          gn[i] = gp[i] | (pp[i] & gp[((i >> l) << l) - 1]);
          pn[i] = pp[i] & pp[((i >> l) << l) - 1];
        end
      end
      gp = gn;
      pp = pn;
    end
    s    = p ^ {gp[SLICE_W-2:0], cin};
    cout = gp[SLICE_W-1];
  end

endmodule

// File: rtl/skl_32_pipe_8.sv
// Elastic pipelined 32-bit adder: one 8-bit Sklansky slice per stage, valid/ready at both ends.
// Operand slices are consumed (zeroed) as they are added so each stage carries only pending work.
module skl_32_pipe_8 #(
  parameter int unsigned WIDTH  = adder_pkg::WIDTH,
  parameter int unsigned SLICE  = adder_pkg::SLICE_W,
  parameter int unsigned STAGES = WIDTH / SLICE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] x2,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  adder_pkg::stage_t  st  [STAGES];
  adder_pkg::stage_t  up  [STAGES];
  adder_pkg::stage_t  nxt [STAGES];
  logic [SLICE-1:0]   sl_s [STAGES];
  logic [STAGES-1:0]  sl_c;
  logic [STAGES-1:0]  rdy;
  logic               unused_ops;

  // Backpressure chain: a stage may load if it is empty or its successor is loading.
  always_comb begin
    rdy = '0;
    rdy[STAGES-1] = !st[STAGES-1].valid || out_ready;
    for (int k = int'(STAGES) - 2; k >= 0; k--) begin
      rdy[k] = !st[k].valid || rdy[k+1];
    end
  end

  assign in_ready = rdy[0];

  // Stage inputs: live operands for stage 0, previous stage register otherwise.
  always_comb begin
    up[0].valid = in_valid;
    up[0].carry = cin;
    up[0].sum   = '0;
    up[0].x1    = x1;
    up[0].x2    = x2;
    for (int k = 1; k < int'(STAGES); k++) begin
      up[k] = st[k-1];
    end
  end

  for (genvar k = 0; k < int'(STAGES); k++) begin : g_slice
    skl8 u_skl8 (
      .a    (up[k].x1[k*SLICE +: SLICE]),
      .b    (up[k].x2[k*SLICE +: SLICE]),
      .cin  (up[k].carry),
      .s    (sl_s[k]),
      .cout (sl_c[k])
    );
  end

  always_comb begin
    for (int k = 0; k < int'(STAGES); k++) begin
      nxt[k]                        = up[k];
      nxt[k].sum[k*SLICE +: SLICE]  = sl_s[k];
      nxt[k].carry                  = sl_c[k];
      nxt[k].x1[k*SLICE +: SLICE]   = '0;
      nxt[k].x2[k*SLICE +: SLICE]   = '0;
    end
  end

  // Data only moves with a valid beat; a bubble just clears the valid bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < int'(STAGES); k++) begin
        st[k] <= '0;
      end
    end else begin
      for (int k = 0; k < int'(STAGES); k++) begin
        if (rdy[k]) begin
          if (up[k].valid) begin
            st[k] <= nxt[k];
          end else begin
            st[k].valid <= 1'b0;
          end
        end
      end
    end
  end

  assign out_valid  = st[STAGES-1].valid;
  assign s          = st[STAGES-1].sum;
  assign cout       = st[STAGES-1].carry;
  assign unused_ops = ^{st[STAGES-1].x1, st[STAGES-1].x2};

endmodule
